// File: rtl/sgmii_comma_align.sv
// SGMII receive comma aligner: locates the K28.5 symbol boundary in the serial
// bit stream, emits aligned 10b symbols and tracks LOS/ACQ/SYNC lock state.
module sgmii_comma_align #(
    parameter logic [9:0]  COMMA_N     = 10'b0011111010,
    parameter logic [9:0]  COMMA_P     = 10'b1100000101,
    parameter int unsigned SYNC_COMMAS = 3,
    parameter int unsigned LOSS_COMMAS = 2
) (
    input  logic       ser_sgmii_clk,
    input  logic       reset,
    input  logic       sgmii_rx_p,
    output logic [9:0] sym10b,
    output logic       sym_valid,
    output logic       sym_comma,
    output logic       sync_ok,
    output logic       realign,
    output logic [7:0] slip_count
);

    typedef enum logic [1:0] {
        ST_LOS,
        ST_ACQ,
        ST_SYNC
    } state_t;

    localparam logic [3:0] SYNC_N = 4'(SYNC_COMMAS);
    localparam logic [3:0] LOSS_N = 4'(LOSS_COMMAS);

    logic [9:0] r_sr;
    logic [3:0] r_bit_cnt;
    state_t     r_state;
    logic [3:0] r_good_cnt;
    logic [3:0] r_bad_cnt;

    logic       w_comma_hit;
    logic       w_bnd;
    logic       w_realign;
    logic       w_emit;
    logic [3:0] w_good_inc;
    logic [3:0] w_bad_inc;

    assign w_comma_hit = (r_sr == COMMA_N) || (r_sr == COMMA_P);
    assign w_bnd       = (r_bit_cnt == 4'd9);
    // A comma re-anchors the boundary when unlocked, or when it lands off-boundary during acquisition.
    assign w_realign   = w_comma_hit &&
                         ((r_state == ST_LOS) || ((r_state == ST_ACQ) && !w_bnd));
    assign w_emit      = w_realign || ((r_state != ST_LOS) && w_bnd);
    assign w_good_inc  = r_good_cnt + 4'd1;
    assign w_bad_inc   = r_bad_cnt + 4'd1;

    // NOTE: every register, including the symbol output, is cleared by the async reset so no stale symbol survives a reset.
    always_ff @(posedge ser_sgmii_clk or negedge reset) begin
        if (!reset) begin
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_state    <= ST_LOS;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
            sym10b     <= '0;
            sym_valid  <= 1'b0;
            sym_comma  <= 1'b0;
            sync_ok    <= 1'b0;
            realign    <= 1'b0;
            slip_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every decision below sees the pre-edge shift register.
            r_sr      <= {r_sr[8:0], sgmii_rx_p};
            sym_valid <= w_emit;
            realign   <= w_realign;

            if (w_emit) begin
                sym10b    <= r_sr;
                sym_comma <= w_comma_hit;
            end

            if (w_realign || w_bnd) begin
                r_bit_cnt <= 4'd0;
            end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end

            if (w_realign && (slip_count != 8'hFF)) begin
                slip_count <= slip_count + 8'd1;
            end

            case (r_state)
                ST_LOS: begin
                    if (w_comma_hit) begin
                        r_good_cnt <= 4'd1;
                        r_bad_cnt  <= 4'd0;
                        if (SYNC_N <= 4'd1) begin
                            r_state <= ST_SYNC;
                            sync_ok <= 1'b1;
                        end else begin
                            r_state <= ST_ACQ;
                        end
                    end
                end
                ST_ACQ: begin
                    if (w_realign) begin
                        r_good_cnt <= 4'd1;
                    end else if (w_comma_hit && w_bnd) begin
                        r_good_cnt <= w_good_inc;
                        if (w_good_inc >= SYNC_N) begin
                            r_state   <= ST_SYNC;
                            r_bad_cnt <= 4'd0;
                            sync_ok   <= 1'b1;
                        end
                    end
                end
                ST_SYNC: begin
                    // Locked: stray commas are counted, never used to move the boundary.
                    if (w_comma_hit) begin
                        if (w_bnd) begin
                            r_bad_cnt <= 4'd0;
                        end else if (w_bad_inc >= LOSS_N) begin
                            r_state    <= ST_LOS;
                            r_good_cnt <= 4'd0;
                            r_bad_cnt  <= 4'd0;
                            sync_ok    <= 1'b0;
                        end else begin
                            r_bad_cnt <= w_bad_inc;
                        end
                    end
                end
                default: begin
                    r_state <= ST_LOS;
                    sync_ok <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sgmii_comma_align.sv
// Bench for sgmii_comma_align: directed serial streams, a boundary-anchor model
// checked every cycle on two parameterisations, plus hand-computed expectations.
module tb_sgmii_comma_align;

    localparam logic [9:0] K_N   = 10'b0011111010;
    localparam logic [9:0] K_P   = 10'b1100000101;
    localparam logic [9:0] D162  = 10'b1001000101;
    localparam int M_LOS = 0, M_ACQ = 1, M_SYNC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;

    logic [9:0] a_sym,   b_sym;
    logic       a_valid, b_valid;
    logic       a_comma, b_comma;
    logic       a_sync,  b_sync;
    logic       a_realn, b_realn;
    logic [7:0] a_slip,  b_slip;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sgmii_comma_align u_a (
        .ser_sgmii_clk (clk),
        .reset         (reset),
        .sgmii_rx_p    (rx),
        .sym10b        (a_sym),
        .sym_valid     (a_valid),
        .sym_comma     (a_comma),
        .sync_ok       (a_sync),
        .realign       (a_realn),
        .slip_count    (a_slip)
    );

    sgmii_comma_align #(.SYNC_COMMAS(1), .LOSS_COMMAS(1)) u_b (
        .ser_sgmii_clk (clk),
        .reset         (reset),
        .sgmii_rx_p    (rx),
        .sym10b        (b_sym),
        .sym_valid     (b_valid),
        .sym_comma     (b_comma),
        .sync_ok       (b_sync),
        .realign       (b_realn),
        .slip_count    (b_slip)
    );

    // Model: the boundary is an absolute edge index (anchor); symbols fall on anchor + 10k.
    typedef struct {
        int         state;
        int         good;
        int         bad;
        int         t;
        int         anchor;
        int         slip;
        int         sync_n;
        int         loss_n;
        logic [9:0] win;
        logic [9:0] sym;
        bit         valid;
        bit         comma;
        bit         realign;
    } model_t;

    model_t m_a, m_b;

    function automatic model_t model_init(int sync_n, int loss_n);
        model_t m;
        m.state = M_LOS; m.good = 0; m.bad = 0; m.t = 0; m.anchor = 0; m.slip = 0;
        m.sync_n = sync_n; m.loss_n = loss_n;
        m.win = '0; m.sym = '0; m.valid = 0; m.comma = 0; m.realign = 0;
        return m;
    endfunction

    function automatic model_t model_step(model_t m, bit b);
        model_t n = m;
        bit hit = (m.win == K_N) || (m.win == K_P);
        bit on_bnd;
        n.t = m.t + 1;
        on_bnd = ((n.t - m.anchor) % 10) == 0;
        n.valid = 0;
        n.realign = 0;
        if (hit && (m.state == M_LOS || (m.state == M_ACQ && !on_bnd))) begin
            n.anchor = n.t; n.realign = 1; n.valid = 1; n.sym = m.win; n.comma = 1;
            if (n.slip < 255) n.slip = n.slip + 1;
            n.good = 1; n.bad = 0;
            n.state = (m.sync_n <= 1) ? M_SYNC : M_ACQ;
        end else if (m.state != M_LOS && on_bnd) begin
            n.valid = 1; n.sym = m.win; n.comma = hit;
            if (hit && m.state == M_ACQ) begin
                n.good = m.good + 1;
                if (n.good >= m.sync_n) begin n.state = M_SYNC; n.bad = 0; end
            end else if (hit) begin
                n.bad = 0;
            end
        end else if (m.state == M_SYNC && hit) begin
            n.bad = m.bad + 1;
            if (n.bad >= m.loss_n) begin n.state = M_LOS; n.good = 0; n.bad = 0; end
        end
        n.win = {m.win[8:0], b};
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cmp(input string tag, input model_t m, input logic v, input logic [9:0] s,
                       input logic c, input logic so, input logic ra, input logic [7:0] sc);
        check({tag, ".sym_valid"},  32'(v),  32'(m.valid));
        check({tag, ".sync_ok"},    32'(so), 32'(m.state == M_SYNC));
        check({tag, ".realign"},    32'(ra), 32'(m.realign));
        check({tag, ".slip_count"}, 32'(sc), 32'(m.slip));
        if (m.valid) begin
            check({tag, ".sym10b"},    32'(s), 32'(m.sym));
            check({tag, ".sym_comma"}, 32'(c), 32'(m.comma));
        end
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            m_a = model_init(3, 2);
            m_b = model_init(1, 1);
        end else begin
            m_a = model_step(m_a, rx);
            m_b = model_step(m_b, rx);
        end
        #1;
        cmp("a", m_a, a_valid, a_sym, a_comma, a_sync, a_realn, a_slip);
        cmp("b", m_b, b_valid, b_sym, b_comma, b_sync, b_realn, b_slip);
    end

    // Drive one bit; returns 2 time units after the edge that sampled it.
    task automatic step(input bit b);
        rx = b;
        @(posedge clk);
        #2;
    endtask

    task automatic send_bits(input logic [9:0] s, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) step(s[i]);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    // Three-bit offset then K28.5/D16.2 pairs; edge numbers count from reset release.
    task automatic run_pairs_from_reset();
        repeat (3) step(1'b1);
        send_bits(K_N, 9, 0);
        send_bits(D162, 9, 9);                       // edge 14: realigning comma
        check("e14.realign",    32'(a_realn), 32'd1);
        check("e14.sym_valid",  32'(a_valid), 32'd1);
        check("e14.sym10b",     32'(a_sym),   32'(K_N));
        check("e14.slip_count", 32'(a_slip),  32'd1);
        check("e14.sync_ok",    32'(a_sync),  32'd0);
        check("e14.b_sync_ok",  32'(b_sync),  32'd1);
        send_bits(D162, 8, 0);
        send_bits(K_N, 9, 9);                        // edge 24: D16.2 symbol
        check("e24.sym_valid",  32'(a_valid), 32'd1);
        check("e24.sym10b",     32'(a_sym),   32'(D162));
        check("e24.sym_comma",  32'(a_comma), 32'd0);
        check("e24.realign",    32'(a_realn), 32'd0);
        send_bits(K_N, 8, 0);
        send_bits(D162, 9, 0);
        send_bits(K_N, 9, 0);                        // ends at edge 53
        check("e53.sync_ok",    32'(a_sync),  32'd0);
        send_bits(D162, 9, 9);                       // edge 54: third aligned comma
        check("e54.sync_ok",    32'(a_sync),  32'd1);
        check("e54.sym_comma",  32'(a_comma), 32'd1);
        check("e54.slip_count", 32'(a_slip),  32'd1);
        send_bits(D162, 8, 8);
        check("e55.sym_valid",  32'(a_valid), 32'd0);
        send_bits(D162, 7, 0);
        repeat (2) begin
            send_bits(K_N, 9, 0);
            send_bits(D162, 9, 0);
        end
    endtask

    initial begin
        reset = 1'b0;
        rx    = 1'b1;

        // Idle lines: all ones, then all zeros.
        do_reset();
        repeat (200) step(1'b1);
        repeat (50)  step(1'b0);
        check("idle.sync_ok",    32'(a_sync), 32'd0);
        check("idle.slip_count", 32'(a_slip), 32'd0);

        // Acquisition, then a one-bit slip while locked.
        do_reset();
        run_pairs_from_reset();
        step(1'b1);
        repeat (2) begin
            send_bits(K_N, 9, 0);
            send_bits(D162, 9, 0);
        end
        check("slip.sync_dropped", 32'(a_sync), 32'd0);
        check("slip.slip_before",  32'(a_slip), 32'd1);
        send_bits(K_N, 9, 0);
        send_bits(D162, 9, 0);
        check("slip.slip_after",   32'(a_slip), 32'd2);
        check("slip.still_acq",    32'(a_sync), 32'd0);
        repeat (2) begin
            send_bits(K_N, 9, 0);
            send_bits(D162, 9, 0);
        end
        check("slip.resync",       32'(a_sync), 32'd1);
        check("slip.b_slip",       32'(b_slip), 32'd2);

        // Reset five bits into a symbol while locked.
        send_bits(K_N, 9, 5);
        #1 reset = 1'b0;
        #1;
        check("arst.sym10b",     32'(a_sym),   32'd0);
        check("arst.sym_valid",  32'(a_valid), 32'd0);
        check("arst.sym_comma",  32'(a_comma), 32'd0);
        check("arst.sync_ok",    32'(a_sync),  32'd0);
        check("arst.realign",    32'(a_realn), 32'd0);
        check("arst.slip_count", 32'(a_slip),  32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        run_pairs_from_reset();

        // Long locked run.
        repeat (200) begin
            send_bits(K_N, 9, 0);
            send_bits(D162, 9, 0);
        end
        check("long.slip_count", 32'(a_slip), 32'd1);
        check("long.sync_ok",    32'(a_sync), 32'd1);

        // Mixed-disparity commas back to back.
        do_reset();
        send_bits(K_N, 9, 0);
        send_bits(K_P, 9, 0);
        send_bits(K_N, 9, 0);                        // edge 30: P emitted at 21
        check("mix.sym10b_p",   32'(a_sym),   32'(K_P));
        check("mix.comma_p",    32'(a_comma), 32'd1);
        check("mix.sync_early", 32'(a_sync),  32'd0);
        send_bits(K_P, 9, 0);                        // edge 40: sync since 31
        check("mix.sync_ok",    32'(a_sync),  32'd1);
        check("mix.sym10b_n",   32'(a_sym),   32'(K_N));
        check("mix.slip_count", 32'(a_slip),  32'd1);

        // Every comma one bit late: forced realign on each.
        do_reset();
        repeat (300) begin
            send_bits(K_N, 9, 0);
            step(1'b1);
        end
        check("sat.slip_count",   32'(a_slip), 32'd255);
        check("sat.b_slip_count", 32'(b_slip), 32'd150);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
